// File: rtl/rfphoenix_vec_writeback_pkg.sv
// rfphoenix_vec_writeback_pkg: shared types and default geometry for the vector writeback sequencer
package rfphoenix_vec_writeback_pkg;
  localparam int WB_NLANES = 16;
  localparam int WB_WLANES = 4;
  localparam int WB_AW = 6;
  localparam int WB_NBEATS = WB_NLANES / WB_WLANES;
  typedef enum logic {WB_IDLE, WB_WRITE} wb_state_t;
  typedef struct packed {
    logic [WB_AW-1:0] tgt;
    logic [WB_NLANES*32-1:0] res;
    logic [WB_NLANES-1:0] mask;
    logic scalar;
  } wb_entry_t;
endpackage

// File: rtl/rfphoenix_wb_grpsel.sv
// rfphoenix_wb_grpsel: lowest lane group at or above start whose mask slice is nonzero
module rfphoenix_wb_grpsel #(
  parameter int NLANES = 16,
  parameter int WLANES = 4,
  localparam int NBEATS = NLANES / WLANES,
  localparam int GW = NBEATS > 1 ? $clog2(NBEATS) : 1
) (
  input  logic [NLANES-1:0] mask,
  input  logic [GW:0]       start,
  output logic [GW-1:0]     grp,
  output logic              none
);
  always_comb begin
    grp = '0;
    none = 1'b1;
    for (int g = NBEATS - 1; g >= 0; g--)
      if (g >= int'(start) && |mask[g*WLANES +: WLANES]) begin
        grp = GW'(g);
        none = 1'b0;
      end
  end
endmodule

// File: rtl/rfphoenix_vec_writeback.sv
// rfphoenix_vec_writeback: buffers two vector results and drains them lane group by lane group
module rfphoenix_vec_writeback
  import rfphoenix_vec_writeback_pkg::*;
#(
  parameter int NLANES = WB_NLANES,
  parameter int WLANES = WB_WLANES,
  parameter int AW = WB_AW,
  localparam int NBEATS = NLANES / WLANES,
  localparam int GW = NBEATS > 1 ? $clog2(NBEATS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_v,
  output logic                   i_rdy,
  input  logic [AW-1:0]          i_tgt,
  input  logic [NLANES*32-1:0]   i_res,
  input  logic [NLANES-1:0]      i_mask,
  input  logic                   i_scalar,
  input  logic                   i_flush,
  output logic [WLANES-1:0]      rf_we,
  output logic [AW-1:0]          rf_wa,
  output logic [GW-1:0]          rf_wg,
  output logic [WLANES*32-1:0]   rf_wd,
  output logic                   o_done,
  output logic [AW-1:0]          o_done_tgt
);
  typedef struct packed {
    logic [AW-1:0] tgt;
    logic [NLANES*32-1:0] res;
    logic [NLANES-1:0] mask;
    logic scalar;
  } entry_t;
  entry_t ent_q [2];
  entry_t head, in_ent, src;
  wb_state_t st, st_n;
  logic [1:0] cnt, cnt_n;
  logic hp, tp, acc, pop, wr, nxt_none, fst_none;
  logic [GW-1:0] bc, bc_n, nxt_g, fst_g;
  logic [NLANES-1:0] head_eff, src_eff;
  assign in_ent = {i_tgt, i_res, i_mask, i_scalar};
  assign head = ent_q[hp];
  // the entry that becomes head next: incoming data unless a second entry is already buffered
  assign src = st == WB_IDLE ? (cnt == 2'd0 ? in_ent : head) : (cnt == 2'd2 ? ent_q[~hp] : in_ent);
  assign head_eff = head.scalar ? NLANES'(head.mask[0]) : head.mask;
  assign src_eff = src.scalar ? NLANES'(src.mask[0]) : src.mask;
  assign wr = st == WB_WRITE;
  assign i_rdy = cnt != 2'd2;
  assign acc = i_v && i_rdy && !i_flush;
  assign pop = wr && nxt_none && !i_flush;
  assign cnt_n = cnt + {1'b0, acc} - {1'b0, pop};
  rfphoenix_wb_grpsel #(.NLANES(NLANES), .WLANES(WLANES)) u_nxt (
    .mask(head_eff), .start((GW+1)'(bc) + (GW+1)'(1)), .grp(nxt_g), .none(nxt_none)
  );
  rfphoenix_wb_grpsel #(.NLANES(NLANES), .WLANES(WLANES)) u_fst (
    .mask(src_eff), .start('0), .grp(fst_g), .none(fst_none)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= WB_IDLE;
      bc <= '0;
      cnt <= '0;
      hp <= 1'b0;
      tp <= 1'b0;
    end else begin
      st <= st_n;
      bc <= bc_n;
      cnt <= i_flush ? 2'd0 : cnt_n;
      hp <= i_flush ? 1'b0 : hp ^ pop;
      tp <= i_flush ? 1'b0 : tp ^ acc;
    end
  always_ff @(posedge clk)
    if (acc) ent_q[tp] <= in_ent;
  always_comb begin
    st_n = i_flush ? WB_IDLE : (st == WB_IDLE || pop) ? (cnt_n != 2'd0 ? WB_WRITE : WB_IDLE) : st;
    bc_n = i_flush ? '0 : (st == WB_IDLE || pop) ? (cnt_n != 2'd0 && !fst_none ? fst_g : '0) : nxt_g;
  end
  always_comb begin
    rf_we = wr && !i_flush ? head_eff[bc*WLANES +: WLANES] : '0;
    rf_wa = wr ? head.tgt : '0;
    rf_wg = wr ? bc : '0;
    rf_wd = wr ? head.res[bc*WLANES*32 +: WLANES*32] : '0;
    o_done = pop;
    o_done_tgt = pop ? head.tgt : '0;
  end
endmodule

// File: tb/tb_rfphoenix_vec_writeback.sv
// tb_rfphoenix_vec_writeback: directed and random checks against a queue-based writeback model
module tb_rfphoenix_vec_writeback;
  logic clk = 1'b0, rst = 1'b1, i_v = 1'b0, i_scalar = 1'b0, i_flush = 1'b0;
  logic [5:0] i_tgt = '0;
  logic [511:0] i_res = '0;
  logic [15:0] i_mask = '0;
  logic i_rdy, o_done;
  logic [3:0] rf_we;
  logic [5:0] rf_wa, o_done_tgt;
  logic [1:0] rf_wg;
  logic [127:0] rf_wd;
  int errs = 0, checks = 0, cyc_n = 0;
  int done_at[$];
  typedef struct {
    logic [5:0] tgt;
    logic [511:0] res;
    logic [15:0] mask;
    logic sc;
  } ent_t;
  ent_t mq[$];
  logic busy = 1'b0, last_acc = 1'b0;
  logic [3:0] rem = '0;

  always #5 clk = ~clk;

  rfphoenix_vec_writeback dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_rdy(i_rdy), .i_tgt(i_tgt), .i_res(i_res),
    .i_mask(i_mask), .i_scalar(i_scalar), .i_flush(i_flush), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wg(rf_wg), .rf_wd(rf_wd), .o_done(o_done), .o_done_tgt(o_done_tgt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] eff(input ent_t e);
    return e.sc ? {15'b0, e.mask[0]} : e.mask;
  endfunction

  function automatic logic [3:0] grps(input ent_t e);
    logic [15:0] m = eff(e);
    for (int g = 0; g < 4; g++) grps[g] = |m[g*4 +: 4];
  endfunction

  function automatic int low(input logic [3:0] r);
    low = 0;
    for (int g = 3; g >= 0; g--) if (r[g]) low = g;
  endfunction

  // one clock: drive inputs, check outputs against the model at negedge, advance model after the edge
  task automatic cyc(input logic v, input logic [5:0] tgt, input logic [511:0] res,
                     input logic [15:0] mask, input logic sc, input logic fl);
    int g;
    logic [15:0] ef;
    logic [3:0] exp_we;
    logic last, acc, popped;
    ent_t ne;
    i_v = v; i_tgt = tgt; i_res = res; i_mask = mask; i_scalar = sc; i_flush = fl;
    @(negedge clk);
    g = low(rem);
    ef = busy ? eff(mq[0]) : '0;
    exp_we = (busy && !fl) ? ef[g*4 +: 4] : 4'd0;
    last = busy && $countones(rem) <= 1;
    if (o_done) done_at.push_back(cyc_n);
    chk("rdy", i_rdy, mq.size() != 2);
    chk("we", rf_we, exp_we);
    chk("done", o_done, last && !fl);
    if (last && !fl) chk("done_tgt", o_done_tgt, mq[0].tgt);
    if (exp_we != 0) begin
      chk("wa", rf_wa, mq[0].tgt);
      chk("wg", rf_wg, g[1:0]);
      chk("wd", rf_wd, mq[0].res[g*128 +: 128]);
    end
    acc = v && mq.size() != 2 && !fl;
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc_n++;
    if (fl) begin
      mq.delete(); busy = 1'b0; rem = '0;
    end else begin
      popped = last;
      if (popped) void'(mq.pop_front());
      else if (busy) rem = rem & (rem - 4'd1);
      if (acc) begin
        ne.tgt = tgt; ne.res = res; ne.mask = mask; ne.sc = sc;
        mq.push_back(ne);
      end
      if (!busy || popped) begin
        busy = mq.size() > 0;
        rem = busy ? grps(mq[0]) : 4'd0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [511:0] lanes;
    int k;
    for (int n = 0; n < 16; n++) lanes[n*32 +: 32] = n;
    #3;
    chk("rst_we", rf_we, 0);
    chk("rst_wa", rf_wa, 0);
    chk("rst_wg", rf_wg, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_done", o_done, 0);
    chk("rst_dtgt", o_done_tgt, 0);
    chk("rst_rdy", i_rdy, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // full vector
    cyc(1'b1, 6'd5, lanes, 16'hFFFF, 1'b0, 1'b0);
    chk("full_b0_wg", rf_wg, 0);
    idle(1);
    chk("full_b1_wg", rf_wg, 1);
    chk("full_b1_wd", rf_wd, {32'd7, 32'd6, 32'd5, 32'd4});
    idle(4);
    // sparse and zero masks
    done_at.delete();
    k = cyc_n;
    cyc(1'b1, 6'd9, lanes, 16'h0F01, 1'b0, 1'b0);
    chk("sp_b0_we", rf_we, 4'h1);
    idle(1);
    chk("sp_b1_wg", rf_wg, 2);
    chk("sp_b1_we", rf_we, 4'hF);
    idle(2);
    chk("sp_done_at", done_at.size() > 0 ? done_at[0] : -1, k + 2);
    cyc(1'b1, 6'd3, lanes, 16'h0000, 1'b0, 1'b0);
    chk("z_we", rf_we, 0);
    idle(2);
    // scalar
    lanes[31:0] = 32'hA5;
    cyc(1'b1, 6'd12, lanes, 16'hFFFF, 1'b1, 1'b0);
    chk("sc_we", rf_we, 4'h1);
    chk("sc_wd", rf_wd[31:0], 32'hA5);
    idle(2);
    // back-pressure: third request held until accepted
    done_at.delete();
    k = cyc_n;
    cyc(1'b1, 6'd21, lanes, 16'hFFFF, 1'b0, 1'b0);
    cyc(1'b1, 6'd22, ~lanes, 16'hFFFF, 1'b0, 1'b0);
    for (int t = 0; t < 10; t++) begin
      cyc(1'b1, 6'd23, {16{32'h5A5A0000}}, 16'hFFFF, 1'b0, 1'b0);
      if (last_acc) break;
    end
    chk("bp_acc3", last_acc, 1);
    idle(12);
    chk("bp_ndone", done_at.size(), 3);
    for (int j = 0; j < done_at.size() && j < 3; j++) chk("bp_done_at", done_at[j], k + 4 * (j + 1));
    // flush at second beat with two entries buffered
    cyc(1'b1, 6'd30, lanes, 16'hFFFF, 1'b0, 1'b0);
    cyc(1'b1, 6'd31, lanes, 16'hFFFF, 1'b0, 1'b0);
    cyc(1'b1, 6'd32, lanes, 16'hFFFF, 1'b0, 1'b1);
    chk("fl_rdy", i_rdy, 1);
    chk("fl_we", rf_we, 0);
    idle(3);
    // async reset mid-beat
    cyc(1'b1, 6'd40, lanes, 16'hFFFF, 1'b0, 1'b0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_wa", rf_wa, 0);
    chk("arst_wd", rf_wd, 0);
    chk("arst_done", o_done, 0);
    chk("arst_rdy", i_rdy, 1);
    #2 rst = 1'b0;
    mq.delete(); busy = 1'b0; rem = '0;
    @(posedge clk); #1;
    cyc(1'b1, 6'd41, ~lanes, 16'hF0F0, 1'b0, 1'b0);
    idle(4);
    // random traffic
    for (int t = 0; t < 400; t++) begin
      logic [511:0] r;
      logic [15:0] m;
      for (int n = 0; n < 16; n++) r[n*32 +: 32] = $urandom();
      m = 16'($urandom());
      for (int g = 0; g < 4; g++) if ($urandom_range(0, 2) == 0) m[g*4 +: 4] = 4'h0;
      cyc($urandom_range(0, 2) != 0, 6'($urandom()), r, m, $urandom_range(0, 4) == 0,
          $urandom_range(0, 40) == 0);
    end
    idle(10);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
